decode_stage: RTL and testbench

Registered RV32IM decode stage sitting between the fetch and execute stages of the pipelined core. It accepts instructions over a valid/ready handshake, decodes them into the core's control-field encoding, and buffers them in a two-entry skid buffer so `in_ready` is driven from a register. It also models the occupancy of the iterative M-extension unit: it holds back issue while a multiply or divide is still in flight.

---
 rtl/decode_stage.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: registered RV32IM decode between fetch and execute.
// Decodes each accepted word into control fields and holds it in a two-entry
// skid buffer (head + skid) so that in_ready comes straight from a flop.
// Optional feature macro: DECODE_MEXT_EN. When defined, M-extension decode
// (mul/div) and the iterative-unit occupancy counter are built in. When left
// undefined, OP encodings with funct7[0]=1 are illegal and out_valid follows
// the head entry directly.
module decode_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 33
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_instr,
  input  logic [DATA_WIDTH-1:0] in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [1:0]            pc_sel,
  output logic [1:0]            result_sel,
  output logic                  mem_write,
  output logic [3:0]            alu_ctrl,
  output logic                  alu_sel,
  output logic [2:0]            imm_sel,
  output logic                  reg_write,
  output logic                  branch,
  output logic [2:0]            mem_ctrl,
  output logic                  mul,
  output logic                  div,
  output logic                  illegal
);

  // Control bundle captured alongside each buffered instruction.
  typedef struct packed {
    logic [1:0] pc_sel;
    logic [1:0] result_sel;
    logic       mem_write;
    logic [3:0] alu_ctrl;
    logic       alu_sel;
    logic [2:0] imm_sel;
    logic       reg_write;
    logic       branch;
    logic [2:0] mem_ctrl;
    logic       mul;
    logic       div;
    logic       illegal;
  } ctrl_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Instruction fields of the incoming word.
  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  ctrl_t      dec;

  assign op = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];

  // Register specifiers and the remaining funct7 bits do not affect control.
  logic unused_bits;
  assign unused_bits = ^{in_instr[24:15], in_instr[11:7], f7[6], f7[4:1]};

  // Buffer state: head entry drives the outputs, skid entry catches overflow.
  logic                  head_valid_reg, head_valid_next;
  logic [DATA_WIDTH-1:0] head_instr_reg, head_instr_next;
  logic [DATA_WIDTH-1:0] head_pc_reg, head_pc_next;
  ctrl_t                 head_ctrl_reg, head_ctrl_next;
  logic                  skid_valid_reg, skid_valid_next;
  logic [DATA_WIDTH-1:0] skid_instr_reg, skid_instr_next;
  logic [DATA_WIDTH-1:0] skid_pc_reg, skid_pc_next;
  ctrl_t                 skid_ctrl_reg, skid_ctrl_next;
  logic                  in_ready_reg, in_ready_next;

  logic accept;
  logic drain;

  // Combinational decode of the word offered by fetch; unlisted fields stay 0.
  always_comb begin
    dec = '0;
    case (op)
      OP_LOAD: begin
        dec.mem_ctrl   = f3;
        dec.reg_write  = 1'b1;
        dec.result_sel = 2'b01;
        dec.alu_sel    = 1'b1;
        dec.imm_sel    = 3'b000;
      end
      OP_STORE: begin
        dec.mem_ctrl  = f3;
        dec.mem_write = 1'b1;
        dec.alu_sel   = 1'b1;
        dec.imm_sel   = 3'b001;
      end
      OP_IMM, OP_REG: begin
        dec.mem_ctrl  = f3;
        dec.reg_write = 1'b1;
        dec.alu_sel   = ~op[5];
        // Bit 3 selects SUB (register form only) and SRA/SRAI.
        dec.alu_ctrl  = {f7[5] & ((f3 == 3'b101) | ((f3 == 3'b000) & op[5])), f3};
`ifdef DECODE_MEXT_EN
        dec.mul = op[5] & f7[0];
        dec.div = op[5] & f7[0] & f3[2];
`else
        // Without the M unit, any M-extension encoding is unsupported.
        if (op[5] & f7[0]) begin
          dec         = '0;
          dec.illegal = 1'b1;
        end
`endif
      end
      OP_BRANCH: begin
        dec.mem_ctrl = f3;
        dec.branch   = 1'b1;
        dec.imm_sel  = 3'b010;
        dec.alu_ctrl = {1'b0, f3};
      end
      OP_LUI, OP_AUIPC: begin
        dec.mem_ctrl   = f3;
        dec.reg_write  = 1'b1;
        dec.result_sel = {~op[5], 1'b0};
        dec.alu_sel    = 1'b1;
        dec.imm_sel    = 3'b011;
        dec.alu_ctrl   = 4'b1111;
      end
      OP_JAL, OP_JALR: begin
        dec.mem_ctrl   = f3;
        dec.pc_sel     = op[3] ? 2'b01 : 2'b10;
        dec.imm_sel    = op[3] ? 3'b100 : 3'b000;
        dec.alu_ctrl   = 4'b0010;
        dec.alu_sel    = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_sel = 2'b11;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

`ifdef DECODE_MEXT_EN
  // Occupancy of the iterative M unit, counted in remaining busy cycles.
  localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int OCC_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [OCC_W-1:0] MUL_LOAD = OCC_W'(MUL_CYCLES - 1);
  localparam logic [OCC_W-1:0] DIV_LOAD = OCC_W'(DIV_CYCLES - 1);

  logic [OCC_W-1:0] occ_reg, occ_next;

  assign out_valid = head_valid_reg & (occ_reg == '0);

  // Load the busy time when an M op issues, otherwise count down to idle.
  // A flush does not touch this: the unit keeps working on what it took.
  always_comb begin
    occ_next = occ_reg;
    if (drain && head_ctrl_reg.mul) begin
      occ_next = head_ctrl_reg.div ? DIV_LOAD : MUL_LOAD;
    end else if (occ_reg != '0) begin
      occ_next = occ_reg - OCC_W'(1);
    end
  end

  // Occupancy counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_reg <= '0;
    end else begin
      occ_reg <= occ_next;
    end
  end
`else
  localparam int unused_cycles = MUL_CYCLES + DIV_CYCLES;

  assign out_valid = head_valid_reg;
`endif

  assign accept = in_valid & in_ready_reg;
  assign drain  = out_valid & out_ready;

  // Skid-buffer movement: flush wins, then drain (refill head), then accept.
  always_comb begin
    head_valid_next = head_valid_reg;
    head_instr_next = head_instr_reg;
    head_pc_next    = head_pc_reg;
    head_ctrl_next  = head_ctrl_reg;
    skid_valid_next = skid_valid_reg;
    skid_instr_next = skid_instr_reg;
    skid_pc_next    = skid_pc_reg;
    skid_ctrl_next  = skid_ctrl_reg;
    if (flush) begin
      head_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (drain) begin
      if (skid_valid_reg) begin
        // in_ready is low whenever skid is full, so no accept can collide here.
        head_valid_next = 1'b1;
        head_instr_next = skid_instr_reg;
        head_pc_next    = skid_pc_reg;
        head_ctrl_next  = skid_ctrl_reg;
        skid_valid_next = 1'b0;
      end else if (accept) begin
        head_valid_next = 1'b1;
        head_instr_next = in_instr;
        head_pc_next    = in_pc;
        head_ctrl_next  = dec;
      end else begin
        head_valid_next = 1'b0;
      end
    end else if (accept) begin
      if (!head_valid_reg) begin
        head_valid_next = 1'b1;
        head_instr_next = in_instr;
        head_pc_next    = in_pc;
        head_ctrl_next  = dec;
      end else begin
        skid_valid_next = 1'b1;
        skid_instr_next = in_instr;
        skid_pc_next    = in_pc;
        skid_ctrl_next  = dec;
      end
    end
    in_ready_next = ~skid_valid_next;
  end

  // Buffer registers; reset empties both entries and zeroes the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_valid_reg <= 1'b0;
      head_instr_reg <= '0;
      head_pc_reg    <= '0;
      head_ctrl_reg  <= '0;
      skid_valid_reg <= 1'b0;
      skid_instr_reg <= '0;
      skid_pc_reg    <= '0;
      skid_ctrl_reg  <= '0;
      in_ready_reg   <= 1'b1;
    end else begin
      head_valid_reg <= head_valid_next;
      head_instr_reg <= head_instr_next;
      head_pc_reg    <= head_pc_next;
      head_ctrl_reg  <= head_ctrl_next;
      skid_valid_reg <= skid_valid_next;
      skid_instr_reg <= skid_instr_next;
      skid_pc_reg    <= skid_pc_next;
      skid_ctrl_reg  <= skid_ctrl_next;
      in_ready_reg   <= in_ready_next;
    end
  end

  assign in_ready   = in_ready_reg;
  assign out_instr  = head_instr_reg;
  assign out_pc     = head_pc_reg;
  assign pc_sel     = head_ctrl_reg.pc_sel;
  assign result_sel = head_ctrl_reg.result_sel;
  assign mem_write  = head_ctrl_reg.mem_write;
  assign alu_ctrl   = head_ctrl_reg.alu_ctrl;
  assign alu_sel    = head_ctrl_reg.alu_sel;
  assign imm_sel    = head_ctrl_reg.imm_sel;
  assign reg_write  = head_ctrl_reg.reg_write;
  assign branch     = head_ctrl_reg.branch;
  assign mem_ctrl   = head_ctrl_reg.mem_ctrl;
  assign mul        = head_ctrl_reg.mul;
  assign div        = head_ctrl_reg.div;
  assign illegal    = head_ctrl_reg.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode table, skid buffer, flush, reset
// and (when DECODE_MEXT_EN is defined) divide occupancy.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_pc;
  logic [1:0]  pc_sel, result_sel;
  logic        mem_write, alu_sel, reg_write, branch, mul, div, illegal;
  logic [3:0]  alu_ctrl;
  logic [2:0]  imm_sel, mem_ctrl;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_AND   = 32'h0020F1B3;
  localparam logic [31:0] I_LW    = 32'h00012083;
  localparam logic [31:0] I_SW    = 32'h00112023;
  localparam logic [31:0] I_BEQ   = 32'h00208063;
  localparam logic [31:0] I_LUI   = 32'h000080B7;
  localparam logic [31:0] I_AUIPC = 32'h00000097;
  localparam logic [31:0] I_JAL   = 32'h000000EF;
  localparam logic [31:0] I_JALR  = 32'h000100E7;
  localparam logic [31:0] I_SRAI  = 32'h40315093;
  localparam logic [31:0] I_ADDI  = 32'hC0010093;
  localparam logic [31:0] I_ZERO  = 32'h00000000;
  localparam logic [31:0] I_MUL   = 32'h027302B3;
  localparam logic [31:0] I_DIV   = 32'h027342B3;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .pc_sel(pc_sel), .result_sel(result_sel), .mem_write(mem_write), .alu_ctrl(alu_ctrl),
    .alu_sel(alu_sel), .imm_sel(imm_sel), .reg_write(reg_write), .branch(branch),
    .mem_ctrl(mem_ctrl), .mul(mul), .div(div), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected control bundle, hand-filled per instruction.
  function automatic logic [31:0] mk(input logic [1:0] ps, input logic [1:0] rs,
      input logic mw, input logic [3:0] ac, input logic as, input logic [2:0] is,
      input logic rw, input logic br, input logic [2:0] mc, input logic mu,
      input logic dv, input logic il);
    return {11'b0, ps, rs, mw, ac, as, is, rw, br, mc, mu, dv, il};
  endfunction

  function automatic logic [31:0] obs_fields();
    return {11'b0, pc_sel, result_sel, mem_write, alu_ctrl, alu_sel, imm_sel,
            reg_write, branch, mem_ctrl, mul, div, illegal};
  endfunction

  // Push one instruction into an empty stage and check it one cycle later.
  task automatic decode_one(input string tag, input logic [31:0] instr,
      input logic [31:0] pc, input logic [31:0] exp);
    @(negedge clk);
    in_valid = 1'b1; in_instr = instr; in_pc = pc; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    $display("txn %s pc=%h instr=%h", tag, pc, instr);
    chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, ".instr"}, out_instr, instr);
    chk({tag, ".fields"}, obs_fields(), exp);
  endtask

  initial begin
    int n;
    logic seen;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    $display("txn reset");
    chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst.in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst.fields", obs_fields(), 32'd0);
    chk("rst.out_instr", out_instr, 32'd0);
    chk("rst.out_pc", out_pc, 32'd0);
    rst_n = 1'b1;

    // ---------------- add then sub (head replaced while draining) ----------------
    @(negedge clk);
    in_valid = 1'b1; in_instr = I_ADD; in_pc = 32'h100; out_ready = 1'b0;
    @(negedge clk);
    $display("txn add pc=%h instr=%h", 32'h100, I_ADD);
    chk("add.valid", {31'b0, out_valid}, 32'd1);
    chk("add.fields", obs_fields(), mk(0, 0, 0, 4'h0, 0, 0, 1, 0, 0, 0, 0, 0));
    chk("add.pc", out_pc, 32'h100);
    in_instr = I_SUB; in_pc = 32'h104; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    $display("txn sub pc=%h instr=%h", 32'h104, I_SUB);
    chk("sub.valid", {31'b0, out_valid}, 32'd1);
    chk("sub.instr", out_instr, I_SUB);
    chk("sub.fields", obs_fields(), mk(0, 0, 0, 4'h8, 0, 0, 1, 0, 0, 0, 0, 0));
    chk("sub.in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    chk("sub.drained", {31'b0, out_valid}, 32'd0);

    // ---------------- decode table ----------------
    decode_one("and",   I_AND,   32'h200, mk(0, 0, 0, 4'h7, 0, 0, 1, 0, 7, 0, 0, 0));
    decode_one("lui",   I_LUI,   32'h204, mk(0, 0, 0, 4'hF, 1, 3, 1, 0, 0, 0, 0, 0));
    decode_one("auipc", I_AUIPC, 32'h208, mk(0, 2, 0, 4'hF, 1, 3, 1, 0, 0, 0, 0, 0));
    decode_one("jal",   I_JAL,   32'h20C, mk(1, 3, 0, 4'h2, 1, 4, 1, 0, 0, 0, 0, 0));
    decode_one("jalr",  I_JALR,  32'h210, mk(2, 3, 0, 4'h2, 1, 0, 1, 0, 0, 0, 0, 0));
    decode_one("srai",  I_SRAI,  32'h214, mk(0, 0, 0, 4'hD, 1, 0, 1, 0, 5, 0, 0, 0));
    decode_one("addi",  I_ADDI,  32'h218, mk(0, 0, 0, 4'h0, 1, 0, 1, 0, 0, 0, 0, 0));
    decode_one("zero",  I_ZERO,  32'h21C, mk(0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1));
`ifdef DECODE_MEXT_EN
    decode_one("mul",   I_MUL,   32'h220, mk(0, 0, 0, 4'h0, 0, 0, 1, 0, 0, 1, 0, 0));
`else
    decode_one("mul",   I_MUL,   32'h220, mk(0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1));
`endif
    @(negedge clk);
    chk("table.drained", {31'b0, out_valid}, 32'd0);

    // ---------------- backpressure: 3 offered, 2 absorbed ----------------
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = I_LW; in_pc = 32'h300;
    @(negedge clk);
    chk("bp.ready_after1", {31'b0, in_ready}, 32'd1);
    in_instr = I_SW; in_pc = 32'h304;
    @(negedge clk);
    chk("bp.ready_after2", {31'b0, in_ready}, 32'd0);
    in_instr = I_BEQ; in_pc = 32'h308;
    @(negedge clk);
    chk("bp.still_full", {31'b0, in_ready}, 32'd0);
    $display("txn bp lw pc=%h instr=%h", out_pc, out_instr);
    chk("bp.head0", out_instr, I_LW);
    chk("bp.lw.fields", obs_fields(), mk(0, 1, 0, 4'h0, 1, 0, 1, 0, 2, 0, 0, 0));
    out_ready = 1'b1;
    @(negedge clk);
    $display("txn bp sw pc=%h instr=%h", out_pc, out_instr);
    chk("bp.head1", out_instr, I_SW);
    chk("bp.sw.pc", out_pc, 32'h304);
    chk("bp.sw.fields", obs_fields(), mk(0, 0, 1, 4'h0, 1, 1, 0, 0, 2, 0, 0, 0));
    chk("bp.sw.valid", {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    $display("txn bp beq pc=%h instr=%h", out_pc, out_instr);
    chk("bp.head2", out_instr, I_BEQ);
    chk("bp.beq.fields", obs_fields(), mk(0, 0, 0, 4'h0, 0, 2, 0, 1, 0, 0, 0, 0));
    chk("bp.beq.valid", {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    chk("bp.drained", {31'b0, out_valid}, 32'd0);

    // ---------------- flush with both entries full and an offer ----------------
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = I_LW; in_pc = 32'h400;
    @(negedge clk);
    in_instr = I_SW; in_pc = 32'h404;
    @(negedge clk);
    flush = 1'b1; in_instr = I_AND; in_pc = 32'h408;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    $display("txn flush_full");
    chk("flush1.out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush1.in_ready", {31'b0, in_ready}, 32'd1);

    // ---------------- flush racing an accept that would land in skid ----------------
    in_valid = 1'b1; in_instr = I_LW; in_pc = 32'h500;
    @(negedge clk);
    flush = 1'b1; in_instr = I_AND; in_pc = 32'h504;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    $display("txn flush_accept");
    chk("flush2.out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush2.in_ready", {31'b0, in_ready}, 32'd1);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk("flush2.never_out", {31'b0, seen}, 32'd0);

`ifdef DECODE_MEXT_EN
    // ---------------- divide occupancy ----------------
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = I_DIV; in_pc = 32'h600;
    @(negedge clk);
    $display("txn div pc=%h instr=%h", out_pc, out_instr);
    chk("div.valid", {31'b0, out_valid}, 32'd1);
    chk("div.fields", obs_fields(), mk(0, 0, 0, 4'h4, 0, 0, 1, 0, 4, 1, 1, 0));
    in_instr = I_ADD; in_pc = 32'h604; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    $display("txn div_stall cycles=%0d", n);
    chk("div.stall_cycles", n, 32'd32);
    chk("div.next_instr", out_instr, I_ADD);
    @(negedge clk);
    chk("div.drained", {31'b0, out_valid}, 32'd0);
`endif

    // ---------------- reset mid-stream with both entries full ----------------
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = I_LUI; in_pc = 32'h700;
    @(negedge clk);
    in_instr = I_JAL; in_pc = 32'h704;
    @(negedge clk);
    in_valid = 1'b0;
    chk("arst.full", {31'b0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    $display("txn async_reset");
    chk("arst.out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst.in_ready", {31'b0, in_ready}, 32'd1);
    chk("arst.fields", obs_fields(), 32'd0);
    chk("arst.out_instr", out_instr, 32'd0);
    chk("arst.out_pc", out_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst.stays_empty", {31'b0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
